// File: rtl/gao_capture_core_if.sv
// ----------------------------------------------------------------------------
// gao_capture_core_if
// Read-back port of the logic-analyser capture engine.
//
// The JTAG control side (master) requests stored samples one at a time.
// The capture core (slave) returns each sample one cycle later, oldest first.
//
// Signals:
//   rd_req_i    master -> slave  request next stored sample
//   rd_valid_o  slave -> master  rd_data_o valid this cycle
//   rd_data_o   slave -> master  read-back sample (PROBE_W bits)
//   rd_last_o   slave -> master  with rd_valid_o: last (DEPTH-th) sample
// ----------------------------------------------------------------------------
interface gao_capture_core_if #(
    parameter int PROBE_W = 89
);
    logic               rd_req_i;
    logic               rd_valid_o;
    logic [PROBE_W-1:0] rd_data_o;
    logic               rd_last_o;

    modport master (
        output rd_req_i,
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_last_o
    );

    modport slave (
        input  rd_req_i,
        output rd_valid_o,
        output rd_data_o,
        output rd_last_o
    );
endinterface

// File: rtl/gao_capture_core.sv
// ----------------------------------------------------------------------------
// gao_capture_core
// On-chip logic-analyser capture engine. Samples a PROBE_W-bit probe bus into
// a circular RAM of 2**DEPTH_LOG2 words. A programmable number of pre-trigger
// samples is kept. The trigger is a masked value compare. After the trigger
// fires, the post-trigger region is filled and capture stops. The captured
// data is then read back oldest-first through the rd interface.
//
// Optional feature: define CAPTURE_QUAL_EN to enable the storage qualifier.
// When it is enabled, only cycles with qual_i=1 write, count and trigger.
//
// Ports:
//   clk_i        sample clock
//   rst_i        asynchronous active-high reset
//   probe_i      probed signals
//   trig_val_i   trigger compare value
//   trig_mask_i  1 = bit participates in compare
//   pre_cnt_i    pre-trigger sample count, latched on arm
//   arm_i        start capture (pulse)
//   abort_i      abandon capture (wins over arm and trigger)
//   qual_i       storage qualifier (CAPTURE_QUAL_EN only)
//   rd           read-back interface (slave side)
//   state_o      0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 DONE
//   triggered_o  trigger seen in current capture
//   done_o       capture complete, buffer readable
//   trig_pos_o   RAM address holding the trigger sample
// ----------------------------------------------------------------------------
module gao_capture_core #(
    parameter int PROBE_W    = 89,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PROBE_W-1:0]    probe_i,
    input  logic [PROBE_W-1:0]    trig_val_i,
    input  logic [PROBE_W-1:0]    trig_mask_i,
    input  logic [DEPTH_LOG2-1:0] pre_cnt_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  qual_i,
    gao_capture_core_if.slave     rd,
    output logic [2:0]            state_o,
    output logic                  triggered_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2-1:0] trig_pos_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [PROBE_W-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_pre;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DEPTH_LOG2-1:0] r_post;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2-1:0] r_rd_cnt;
    logic [DEPTH_LOG2-1:0] r_trig_pos;
    logic                  r_trig;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [PROBE_W-1:0]    r_rd_data;

    logic w_qual;
    logic w_hit;
    logic w_write;
    logic w_start;

`ifdef CAPTURE_QUAL_EN
    assign w_qual = qual_i;
`else
    logic w_unused_qual;
    assign w_unused_qual = qual_i;
    assign w_qual        = 1'b1;
`endif

    always_comb begin
        w_hit   = ((probe_i ^ trig_val_i) & trig_mask_i) == '0;
        w_start = arm_i && !abort_i && (r_state == S_IDLE || r_state == S_DONE);
        w_write = 1'b0;
        // A zero pre count spends its one PRE cycle without storing anything.
        if (!abort_i && w_qual) begin
            unique case (r_state)
                S_PRE:          w_write = (r_pre != '0);
                S_ARMED, S_POST: w_write = 1'b1;
                default:        w_write = 1'b0;
            endcase
        end
    end

    // Sample RAM: no reset, zero probe-to-RAM latency.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wptr] <= probe_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_cnt      <= '0;
            r_post     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_cnt   <= '0;
            r_trig_pos <= '0;
            r_trig     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (w_write) begin
                r_wptr <= r_wptr + 1'b1;
            end

            if (abort_i) begin
                r_state <= S_IDLE;
                r_trig  <= 1'b0;
                r_done  <= 1'b0;
            end else if (w_start) begin
                // pre_cnt_i is DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1.
                r_pre   <= pre_cnt_i;
                r_cnt   <= '0;
                r_wptr  <= '0;
                r_trig  <= 1'b0;
                r_done  <= 1'b0;
                r_state <= S_PRE;
            end else begin
                unique case (r_state)
                    S_PRE: begin
                        if (r_pre == '0) begin
                            r_state <= S_ARMED;
                        end else if (w_write) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (DEPTH_LOG2'(r_cnt + 1'b1) == r_pre) begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (w_write && w_hit) begin
                            r_trig_pos <= r_wptr;
                            r_trig     <= 1'b1;
                            // All-ones minus pre is DEPTH-1-pre in DEPTH_LOG2 bits.
                            r_post     <= '1 - r_pre;
                            if (r_pre == '1) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_rptr   <= r_wptr - r_pre;
                                r_rd_cnt <= '0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (w_write) begin
                            r_post <= r_post - 1'b1;
                            if (r_post == DEPTH_LOG2'(1)) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_rptr   <= r_trig_pos - r_pre;
                                r_rd_cnt <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        // Pointer and read count wrap naturally modulo DEPTH,
                        // so the read after the last sample returns to the oldest.
                        if (rd.rd_req_i) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= r_mem[r_rptr];
                            r_rd_last  <= (r_rd_cnt == '1);
                            r_rptr     <= r_rptr + 1'b1;
                            r_rd_cnt   <= r_rd_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign state_o        = r_state;
    assign triggered_o    = r_trig;
    assign done_o         = r_done;
    assign trig_pos_o     = r_trig_pos;
    assign rd.rd_valid_o  = r_rd_valid;
    assign rd.rd_data_o   = r_rd_data;
    assign rd.rd_last_o   = r_rd_last;
endmodule

// File: tb/tb_gao_capture_core.sv
// ----------------------------------------------------------------------------
// tb_gao_capture_core
// Directed test of gao_capture_core with PROBE_W=8, DEPTH=16.
// Probe ramps 1,2,3,... one value per clock after arming on probe 0.
// ----------------------------------------------------------------------------
module tb_gao_capture_core;
    localparam int PW = 8;
    localparam int DL = 4;

`ifdef CAPTURE_QUAL_EN
    localparam logic QBASE = 1'b1;
`else
    localparam logic QBASE = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [PW-1:0] probe_i = '0;
    logic [PW-1:0] trig_val_i = '0;
    logic [PW-1:0] trig_mask_i = '0;
    logic [DL-1:0] pre_cnt_i = '0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          qual_i = QBASE;
    logic [2:0]    state_o;
    logic          triggered_o;
    logic          done_o;
    logic [DL-1:0] trig_pos_o;

    int n_checks = 0;
    int n_fail   = 0;

    gao_capture_core_if #(.PROBE_W(PW)) rd_if ();

    gao_capture_core #(
        .PROBE_W   (PW),
        .DEPTH_LOG2(DL)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .probe_i    (probe_i),
        .trig_val_i (trig_val_i),
        .trig_mask_i(trig_mask_i),
        .pre_cnt_i  (pre_cnt_i),
        .arm_i      (arm_i),
        .abort_i    (abort_i),
        .qual_i     (qual_i),
        .rd         (rd_if),
        .state_o    (state_o),
        .triggered_o(triggered_o),
        .done_o     (done_o),
        .trig_pos_o (trig_pos_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arm on probe 0, then ramp 1..63 until DONE; check completion point.
    task automatic run_ramp(input int pre, input int exp_done_p, input int exp_pos);
        int done_p;
        done_p      = -1;
        pre_cnt_i   = DL'(pre);
        trig_val_i  = 8'h2A;
        trig_mask_i = 8'hFF;
        probe_i     = 8'd0;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("arm_to_pre", 32'(state_o), 32'd1);
        for (int p = 1; p < 64; p++) begin
            probe_i = 8'(p);
            tick();
            if (state_o == 3'd4) begin
                done_p = p;
                break;
            end
        end
        chk("done_at_probe", 32'(done_p), 32'(exp_done_p));
        chk("done_o", 32'(done_o), 32'd1);
        chk("triggered_o", 32'(triggered_o), 32'd1);
        chk("trig_pos_o", 32'(trig_pos_o), 32'(exp_pos));
    endtask

    // Read all 16 samples, then one more to confirm wrap to oldest.
    task automatic readback(input int first, input int stride);
        rd_if.rd_req_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rd_valid", 32'(rd_if.rd_valid_o), 32'd1);
            chk("rd_data", 32'(rd_if.rd_data_o), 32'(8'(first + stride * i)));
            chk("rd_last", 32'(rd_if.rd_last_o), 32'(i == 15));
        end
        tick();
        chk("rd_wrap_data", 32'(rd_if.rd_data_o), 32'(8'(first)));
        chk("rd_wrap_last", 32'(rd_if.rd_last_o), 32'd0);
        rd_if.rd_req_i = 1'b0;
        tick();
        chk("rd_idle_valid", 32'(rd_if.rd_valid_o), 32'd0);
    endtask

    initial begin
        int k;
        rd_if.rd_req_i = 1'b0;

        // Reset state
        #3;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_triggered", 32'(triggered_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_trig_pos", 32'(trig_pos_o), 32'd0);
        chk("rst_rd_valid", 32'(rd_if.rd_valid_o), 32'd0);
        chk("rst_rd_data", 32'(rd_if.rd_data_o), 32'd0);
        #6 rst_i = 1'b0;
        tick();

        // Read request outside DONE is ignored
        rd_if.rd_req_i = 1'b1;
        tick();
        chk("idle_rd_valid", 32'(rd_if.rd_valid_o), 32'd0);
        rd_if.rd_req_i = 1'b0;

        // 1: pre=4, trigger on 0x2A at addr 9, readback 0x26..0x35
        run_ramp(4, 53, 9);
        readback(8'h26, 1);

        // 2: pre=0, mask=0: trigger on first ARMED cycle, no write in PRE
        pre_cnt_i   = '0;
        trig_mask_i = '0;
        probe_i     = 8'd100;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("t2_pre", 32'(state_o), 32'd1);
        probe_i = 8'd101;
        tick();
        chk("t2_armed", 32'(state_o), 32'd2);
        probe_i = 8'd102;
        tick();
        chk("t2_post", 32'(state_o), 32'd3);
        chk("t2_triggered", 32'(triggered_o), 32'd1);
        chk("t2_trig_pos", 32'(trig_pos_o), 32'd0);
        chk("t2_not_done", 32'(done_o), 32'd0);
        k = -1;
        for (int j = 3; j < 24; j++) begin
            probe_i = 8'(100 + j);
            tick();
            if (state_o == 3'd4) begin
                k = j;
                break;
            end
        end
        chk("t2_done_at", 32'(k), 32'd17);
        readback(102, 1);

        // 3: pre_cnt 31 truncates to 15 on a 4-bit port; trigger read back last
        run_ramp(31, 42, 9);
        readback(27, 1);

        // 4: abort in the same cycle as a hit
        pre_cnt_i   = 4'd4;
        trig_val_i  = 8'h2A;
        trig_mask_i = 8'hFF;
        probe_i     = 8'd0;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int p = 1; p < 42; p++) begin
            probe_i = 8'(p);
            tick();
        end
        chk("t4_armed", 32'(state_o), 32'd2);
        probe_i = 8'h2A;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t4_state", 32'(state_o), 32'd0);
        chk("t4_triggered", 32'(triggered_o), 32'd0);
        chk("t4_done", 32'(done_o), 32'd0);
        rd_if.rd_req_i = 1'b1;
        tick();
        chk("t4_rd_valid", 32'(rd_if.rd_valid_o), 32'd0);
        rd_if.rd_req_i = 1'b0;
        run_ramp(4, 53, 9);
        readback(8'h26, 1);

`ifdef CAPTURE_QUAL_EN
        // 5: qual on even probes only; odd hit on 0x21 ignored
        pre_cnt_i   = 4'd2;
        trig_val_i  = 8'h21;
        trig_mask_i = 8'hFF;
        probe_i     = 8'd0;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        k = -1;
        for (int p = 1; p < 90; p++) begin
            probe_i    = 8'(p);
            qual_i     = (p % 2) == 0;
            trig_val_i = (p <= 41) ? 8'h21 : 8'h2A;
            tick();
            if (p == 41) chk("t5_no_trig", 32'(triggered_o), 32'd0);
            if (state_o == 3'd4) begin
                k = p;
                break;
            end
        end
        qual_i = QBASE;
        chk("t5_done_at", 32'(k), 32'd68);
        chk("t5_trig_pos", 32'(trig_pos_o), 32'd4);
        readback(38, 2);
`endif

        // 6: async reset while in POST
        pre_cnt_i   = 4'd4;
        trig_val_i  = 8'h2A;
        trig_mask_i = 8'hFF;
        probe_i     = 8'd0;
        arm_i       = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int p = 1; p <= 45; p++) begin
            probe_i = 8'(p);
            tick();
        end
        chk("t6_post", 32'(state_o), 32'd3);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_state", 32'(state_o), 32'd0);
        chk("t6_triggered", 32'(triggered_o), 32'd0);
        chk("t6_done", 32'(done_o), 32'd0);
        chk("t6_trig_pos", 32'(trig_pos_o), 32'd0);
        chk("t6_rd_data", 32'(rd_if.rd_data_o), 32'd0);
        chk("t6_rd_last", 32'(rd_if.rd_last_o), 32'd0);
        rst_i = 1'b0;
        rd_if.rd_req_i = 1'b1;
        tick();
        chk("t6_rd_valid_a", 32'(rd_if.rd_valid_o), 32'd0);
        chk("t6_idle", 32'(state_o), 32'd0);
        tick();
        chk("t6_rd_valid_b", 32'(rd_if.rd_valid_o), 32'd0);
        rd_if.rd_req_i = 1'b0;
        run_ramp(4, 53, 9);
        readback(8'h26, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
